program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits directly upstream of the processor's instruction RAM. It accepts a byte stream over a valid/ready handshake and writes it into the RAM write port (`write_en`, `write_adress`, `data_in`). It holds the processor core in reset until a complete image has been written. Image format: one length byte, then the payload bytes, then an optional checksum byte.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: RAM address width. It must match the RAM write port.
- `DATA_WIDTH`, default 8: byte width of the stream and of RAM words.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `start`  input  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- `abort`  input  1  level; while high in LEN, LOAD or CSUM, the next edge goes to ERR.
- `in_valid`  input  1  the stream byte on `in_data` is valid.
- `in_data`  input  DATA_WIDTH  stream byte.
- `in_ready`  output  1  the loader accepts a byte this cycle.
- `ram_write_en`  output  1  RAM write strobe, one cycle per payload byte.
- `ram_write_adress`  output  ADDR_WIDTH  RAM write address.
- `ram_data_in`  output  DATA_WIDTH  RAM write data.
- `cpu_hold`  output  1  high means the processor is kept in reset.
- `busy`  output  1  high in LEN, LOAD and CSUM.
- `done`  output  1  high in DONE.
- `error`  output  1  high in ERR.
- `byte_count`  output  ADDR_WIDTH+1  number of payload bytes written so far in the current load.

## Operation

- The state machine has six states: IDLE, LEN, LOAD, CSUM, DONE, ERR.
- A handshake occurs on a rising edge when `in_valid && in_ready`.
- `in_ready` is combinational and equals `busy`.
- IDLE/DONE/ERR + `start` → LEN. On this transition `byte_count`, the address counter, the checksum accumulator and `error` are cleared.
- LEN, on handshake:
  - the length register latches `in_data`;
  - value 0 means 2^ADDR_WIDTH (256) bytes;
  - the state goes to LOAD.
- LOAD, on handshake:
  - the byte is written to address = `byte_count` (truncated to ADDR_WIDTH bits), starting at address 0;
  - `byte_count` increments;
  - the byte is added to the checksum accumulator, modulo 2^DATA_WIDTH.
- After the last payload byte, LOAD goes to CSUM if the checksum feature is compiled in, otherwise to DONE.
- CSUM, on handshake:
  - if (accumulator + byte) mod 256 == 0, the state goes to DONE;
  - otherwise it goes to ERR.
- DONE: `cpu_hold` = 0 and the processor runs. The state stays in DONE until `start` or reset.
- ERR: `cpu_hold` = 1 and `error` = 1. The state stays in ERR until `start` or reset.
- `abort` has priority over a handshake in the same cycle. The byte is not written and the state goes to ERR.
- `start` while busy is ignored.
- `in_valid` outside the busy states is ignored, and no byte is consumed.
- A full 256-byte image fills addresses 0..255 exactly, and the address never wraps within one load. `byte_count` reaches 256, which is why it is ADDR_WIDTH+1 bits wide.
- A new `start` from DONE asserts `cpu_hold` again in the next cycle and overwrites the RAM from address 0.

## Timing

- Reset values:
  - state = IDLE;
  - `cpu_hold` = 1;
  - `ram_write_en`, `busy`, `done`, `error`, `in_ready` = 0;
  - `ram_write_adress`, `ram_data_in`, `byte_count` = 0.
- Reset mid-load returns to IDLE at once. Any write strobe in flight is dropped, and the RAM contents are left as they are.
- `ram_write_en`, `ram_write_adress` and `ram_data_in` are registered.
  - The strobe is high exactly one cycle, the cycle after the handshake.
  - Outside a strobe, address and data hold their last values.
- Throughput is one byte per cycle. With `in_valid` held high, N payload bytes take N consecutive cycles in LOAD.
- State timing:
  - LEN is entered 1 cycle after `start`.
  - DONE is entered on the edge of the last accepted byte (payload, or checksum if enabled).
  - `done` rises and `cpu_hold` falls in that same edge's cycle.
- The last RAM strobe occurs in the first DONE cycle, or the first CSUM cycle. Consumers must not fetch before `cpu_hold` is low for one full cycle; the RAM write lands in that cycle.

## Configuration

- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - the CSUM state and the 8-bit accumulator exist;
  - the image is length + payload + checksum byte;
  - a mismatch ends in ERR.
- Not defined:
  - there is no CSUM state and no accumulator;
  - LOAD goes straight to DONE;
  - ERR is reachable only via `abort`.

## Test plan

- **Basic load (no checksum):** after reset, `start`, then stream 0x03, 0xA1, 0xB2, 0xC3 back-to-back → RAM[0..2] = A1, B2, C3. Three single-cycle strobes at addresses 0, 1, 2. `done` = 1, `cpu_hold` = 0, `byte_count` = 3.
- **Checksum (macro on):** stream 0x02, 0x10, 0x20, 0xD0 → DONE. The same stream with final byte 0xD1 → ERR, `error` = 1, `cpu_hold` = 1.
- **Length 0:** stream 0x00 then 256 bytes of value i → RAM[i] = i for i = 0..255, `byte_count` = 256, no write to address 0 after the first.
- **Backpressure and gaps:** `in_valid` toggling every other cycle with 0x04 + 4 bytes → 4 writes only on handshake cycles. `start` pulsed mid-load → ignored.
- **Abort:** raise `abort` in the same cycle as the 2nd payload handshake → only RAM[0] is written, then ERR. A new `start` → LEN with `error` cleared.
- **Reset mid-load:** drop `rst` low asynchronously during LOAD → all outputs reach reset values without a clock edge, and the state is IDLE after release.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time image loader: streams length + payload (+ checksum byte when
// PROGRAM_LOADER_CHECKSUM_EN is defined) into instruction RAM, holding the CPU in reset until done.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_adress,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic [ADDR_WIDTH:0]   len_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hs;
  logic                  in_csum;

  // A length byte of zero encodes a full 2^ADDR_WIDTH image.
  assign len_d   = (in_data == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : (ADDR_WIDTH+1)'(in_data);
  assign count_d = count_q + 1'b1;
  assign hs      = in_valid && in_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic [DATA_WIDTH-1:0] csum_d;
  assign csum_d  = csum_q + in_data;
  assign in_csum = (state_q == S_CSUM);
`else
  assign in_csum = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q <= S_LEN;
            count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        S_LEN: begin
          if (abort) begin
            state_q <= S_ERR;
          end else if (hs) begin
            len_q   <= len_d;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_q <= S_ERR;
          end else if (hs) begin
            we_q    <= 1'b1;
            addr_q  <= count_q[ADDR_WIDTH-1:0];
            data_q  <= in_data;
            count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            if (count_d == len_q) state_q <= S_CSUM;
`else
            if (count_d == len_q) state_q <= S_DONE;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (abort) begin
            state_q <= S_ERR;
          end else if (hs) begin
            state_q <= (csum_d == '0) ? S_DONE : S_ERR;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = (state_q == S_LEN) || (state_q == S_LOAD) || in_csum;
  assign in_ready         = busy;
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_ERR);
  assign cpu_hold         = !done;
  assign byte_count       = count_q;
  assign ram_write_en     = we_q;
  assign ram_write_adress = addr_q;
  assign ram_data_in      = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a transaction-level reference model;
// honours PROGRAM_LOADER_CHECKSUM_EN when defined for both bench and design.
`timescale 1ns/1ps
module tb_program_loader;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_write_en, cpu_hold, busy, done, error;
  logic [7:0] ram_write_adress, ram_data_in;
  logic [8:0] byte_count;

  program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_write_en(ram_write_en), .ram_write_adress(ram_write_adress),
    .ram_data_in(ram_data_in), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phase: 0 idle, 1 awaiting length, 2 payload, 3 checksum, 4 done, 5 error.
  int m_phase = 0;
  int m_left  = 0;
  int m_count = 0;
  int m_sum   = 0;
  int m_we    = 0;
  int m_addr  = 0;
  int m_data  = 0;
  int model_ram[256];
  int dut_ram[256];
  int n_wr = 0;
  int n_wr0 = 0;

  function automatic bit m_busy();
    return (m_phase >= 1) && (m_phase <= 3);
  endfunction

  task automatic model_step();
    int d;
    d = int'(in_data);
    if (!rst) begin
      m_phase = 0; m_count = 0; m_sum = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (!m_busy()) begin
        if (start) begin
          m_phase = 1; m_count = 0; m_sum = 0;
        end
      end else if (abort) begin
        m_phase = 5;
      end else if (in_valid) begin
        if (m_phase == 1) begin
          m_left  = (d == 0) ? 256 : d;
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_we = 1;
          m_addr = m_count % 256;
          m_data = d;
          model_ram[m_addr] = d;
          m_count++;
          m_sum = (m_sum + d) % 256;
          m_left--;
          if (m_left == 0) m_phase = CSUM_EN ? 3 : 4;
        end else begin
          m_phase = ((m_sum + d) % 256 == 0) ? 4 : 5;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare and RAM mirror, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (ram_write_en) begin
      dut_ram[ram_write_adress] = int'(ram_data_in);
      n_wr++;
      if (ram_write_adress == 8'd0) n_wr0++;
    end
    chk("in_ready", int'(in_ready), int'(m_busy()));
    chk("busy", int'(busy), int'(m_busy()));
    chk("done", int'(done), int'(m_phase == 4));
    chk("error", int'(error), int'(m_phase == 5));
    chk("cpu_hold", int'(cpu_hold), int'(m_phase != 4));
    chk("byte_count", int'(byte_count), m_count);
    chk("ram_write_en", int'(ram_write_en), m_we);
    chk("ram_write_adress", int'(ram_write_adress), m_addr);
    chk("ram_data_in", int'(ram_data_in), m_data);
  end

  task automatic tick(input bit s, input bit a, input bit v, input logic [7:0] d);
    @(negedge clk);
    start = s; abort = a; in_valid = v; in_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d, input int maxgap);
    repeat ($urandom_range(0, maxgap)) tick($urandom_range(0, 7) == 0, 1'b0, 1'b0, 8'($urandom));
    tick(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    settle();
    n_wr = 0;
    n_wr0 = 0;
  endtask

  task automatic ram_cmp(input string name);
    for (int i = 0; i < 256; i++) chk(name, dut_ram[i], model_ram[i]);
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] q[$]);
    int s;
    s = 0;
    for (int i = 1; i < q.size(); i++) s += int'(q[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic run_image(input logic [7:0] q[$], input int maxgap);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    foreach (q[i]) send(q[i], maxgap);
    idle(2);
  endtask

  task automatic rand_image();
    int len, gap, abort_at;
    logic [7:0] q[$];
    len = $urandom_range(1, 24);
    gap = $urandom_range(0, 2);
    abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
    q.push_back(8'(len));
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    q.push_back(csum_of(q) ^ 8'(($urandom_range(0, 3) == 0) ? 1 : 0));
`endif
    if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b1, 8'($urandom));
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    foreach (q[i]) begin
      if (i == abort_at) begin
        tick(1'b0, 1'b1, 1'b1, q[i]);
        break;
      end
      send(q[i], gap);
    end
    idle(2);
    ram_cmp("rand_ram");
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b0;
    for (int i = 0; i < 256; i++) begin
      model_ram[i] = -1;
      dut_ram[i] = -1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cpu_hold", int'(cpu_hold), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_byte_count", int'(byte_count), 0);
    chk("rst_write_en", int'(ram_write_en), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Basic load
    clear_counts();
    q = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    if (CSUM_EN) q.push_back(csum_of(q));
    run_image(q, 0);
    settle();
    chk("basic_ram0", dut_ram[0], 'hA1);
    chk("basic_ram1", dut_ram[1], 'hB2);
    chk("basic_ram2", dut_ram[2], 'hC3);
    chk("basic_writes", n_wr, 3);
    chk("basic_done", int'(done), 1);
    chk("basic_cpu_hold", int'(cpu_hold), 0);
    chk("basic_byte_count", int'(byte_count), 3);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    run_image('{8'h02, 8'h10, 8'h20, 8'hD0}, 0);
    settle();
    chk("csum_good_done", int'(done), 1);
    run_image('{8'h02, 8'h10, 8'h20, 8'hD1}, 0);
    settle();
    chk("csum_bad_error", int'(error), 1);
    chk("csum_bad_cpu_hold", int'(cpu_hold), 1);
`endif

    // Length 0 means a full 256-byte image
    clear_counts();
    q = '{8'h00};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    if (CSUM_EN) q.push_back(8'h80);
    run_image(q, 0);
    settle();
    for (int i = 0; i < 256; i++) chk("len0_ram", dut_ram[i], i);
    chk("len0_byte_count", int'(byte_count), 256);
    chk("len0_addr0_writes", n_wr0, 1);
    chk("len0_writes", n_wr, 256);
    chk("len0_done", int'(done), 1);

    // Backpressure with a start pulse mid-load
    clear_counts();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h04, 0);
    q = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 1; i <= 4; i++) begin
      tick(i == 2, 1'b0, 1'b0, 8'hEE);
      tick(1'b0, 1'b0, 1'b1, q[i]);
    end
    if (CSUM_EN) send(csum_of(q), 1);
    idle(2);
    settle();
    chk("bp_writes", n_wr, 4);
    chk("bp_byte_count", int'(byte_count), 4);
    chk("bp_done", int'(done), 1);
    chk("bp_ram3", dut_ram[3], 'h44);

    // Abort on the second payload handshake
    clear_counts();
    b0 = 8'($urandom);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h05, 0);
    send(b0, 0);
    tick(1'b0, 1'b1, 1'b1, 8'h5A);
    idle(2);
    settle();
    chk("abort_error", int'(error), 1);
    chk("abort_writes", n_wr, 1);
    chk("abort_ram0", dut_ram[0], int'(b0));
    chk("abort_byte_count", int'(byte_count), 1);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    chk("restart_error", int'(error), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_byte_count", int'(byte_count), 0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);

    // Randomized images
    for (int n = 0; n < 40; n++) rand_image();

    // Asynchronous reset during LOAD, while a strobe is in flight
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'd10, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_write_en", int'(ram_write_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_cpu_hold", int'(cpu_hold), 1);
    chk("arst_byte_count", int'(byte_count), 0);
    chk("arst_addr", int'(ram_write_adress), 0);
    chk("arst_data", int'(ram_data_in), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    settle();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
